bnn_layer_core: RTL and testbench
=================================

Name: bnn_layer_core

Overview:
- Parametrised successor of the first-layer control-and-accumulate path.
- Reads im2col-ordered pixels from a ping-pong input SRAM pair and 1-bit weights for N_CH output channels.
- Accumulates ±pixel per channel, applies a per-channel BN threshold with sign flip, packs the N_CH result bits and writes them to a ping-pong output SRAM pair.
- Handles bank alternation and full/empty handshakes on both sides autonomously.

Parameters:
IMG_W, 16, signed pixel width
ACC_W, 24, signed accumulator width (must be ≥ IMG_W + clog2(K_LEN))
BN_W, 16, signed BN threshold width; BN word = {flip, threshold} = BN_W+1 bits
N_CH, 8, parallel output channels = weight word width = output word width
K_LEN, 9, taps per output pixel
N_OUT, 64, output pixels per bank (tile)
PRE_AW, 10, input SRAM address width (must hold N_OUT*K_LEN)
NEXT_AW, 13, output SRAM address width
W_AW, 9, weight SRAM address width
BN_AW, 7, BN SRAM address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
pre_sram_full1/pre_sram_full2  in  1 each  input bank holds a complete tile
img_request1/img_request2  out  1 each  one-cycle pulse: input bank consumed, refill
pre_en1/pre_en2  out  1 each  input bank chip select, active-low
pre_rd  out  1  input read strobe, active-low
pre_addr  out  PRE_AW  input read address
pre_data  in  IMG_W  input read data, valid 1 cycle after strobe
weight_en  out  1  weight SRAM select+read, active-low
weight_addr  out  W_AW  weight address
weight_data  in  N_CH  weight bits, 1 = +1, 0 = −1; 1-cycle latency
bn_en  out  1  BN SRAM select+read, active-low
bn_addr  out  BN_AW  BN address = channel index
bn_data  in  BN_W+1  {flip, signed threshold}; 1-cycle latency
next_sram_empty1/next_sram_empty2  in  1 each  output bank free
next_en1/next_en2  out  1 each  output bank select, active-low
next_wr  out  1  output write strobe, active-low
next_addr  out  NEXT_AW  output write address
next_data  out  N_CH  packed output bits, bit c = channel c
next_sram_full1/next_sram_full2  out  1 each  one-cycle pulse: output bank complete
busy  out  1  high in every state except IDLE/WAIT

Behaviour:
- Reset: all active-low strobes/selects = 1; addresses, next_data, pulses, busy = 0; accumulators = 0; FSM = IDLE; in_sel = out_sel = bank1. Reset mid-tile abandons the tile and emits no pulse.
- IDLE → WAIT in one cycle.
- WAIT:
  - Advance to MAC when the input bank at in_sel is full AND the output bank at out_sel is empty.
  - Only the selected bank is considered; other-bank flags are ignored.
  - Sets o = 0.
- MAC, cycles k = 0..K_LEN:
  - Cycles k < K_LEN issue: pre_rd = 0, pre_en(in_sel) = 0, pre_addr = o*K_LEN + k; weight_en = 0, weight_addr = k.
  - Cycle k ≥ 1 consumes tap k−1: acc[c] += weight_data[c] ? sext(pre_data) : −sext(pre_data).
  - Accumulation wraps modulo 2^ACC_W.
  - Accumulators clear on MAC entry, so the first accumulate sees 0.
  - Duration: K_LEN+1 cycles.
- BN, cycles c = 0..N_CH:
  - Cycles c < N_CH issue bn_en = 0, bn_addr = c.
  - Cycle c ≥ 1 computes bit[c−1] = (acc[c−1] ≥ sext(threshold)) XOR flip.
  - Duration: N_CH+1 cycles.
- WRITE, 1 cycle: next_wr = 0, next_en(out_sel) = 0, next_addr = o, next_data = packed bits.
  - If o < N_OUT−1: o += 1 and return to MAC.
  - Else go to DONE.
- DONE, 1 cycle:
  - Pulse img_request(in_sel) and next_sram_full(out_sel).
  - Toggle in_sel and out_sel; go to WAIT.
- Strobes are inactive outside their issuing cycles; next_data holds its last value.
- Per-output latency: K_LEN + N_CH + 3 cycles. Per tile: N_OUT × that + 2 (WAIT/DONE, excluding stall).
- Full and empty flags may drop or rise mid-tile; they are sampled only in WAIT.

Test Plan:
- Reset with rst = 0 mid-MAC → all selects/strobes 1, busy 0; after release, the FSM waits in WAIT with no img_request or next_sram_full pulse.
- K_LEN = 9, N_CH = 8, pixels all +5, weight_data = 8'b1010_1010, thresholds 0, flip 0 → acc = {+45, −45, …}; next_data = 8'hAA at next_addr 0; total 20 cycles from MAC entry to WRITE.
- Same stimulus with flip = 1 on channel 0, threshold = 45 on channel 1 → bit0 = 1, bit1 = 1 (45 ≥ 45); next_data = 8'hAB.
- Bank alternation: pre_sram_full1 = full2 = 1, next_empty both 1, N_OUT = 4 → tile 1 reads only pre_en1 and writes only next_en1; DONE pulses img_request1 and next_sram_full1; tile 2 uses bank 2.
- Stall: pre bank1 full, next_sram_empty1 = 0 for 50 cycles → FSM stays in WAIT, pre_rd held 1, busy 0; MAC starts 1 cycle after empty1 rises.
- Extremes: IMG_W = 16, pixels = −32768, weights 0, K_LEN = 9 → acc = +294912 with no wrap at ACC_W = 24; threshold 32767 → bit = 1.

Source files
------------

// File: rtl/bnn_layer_core.sv
// rtl/bnn_layer_core.sv - binary conv layer core: ping-pong input, +/-pixel MAC, BN threshold, packed ping-pong output
module bnn_layer_core #(
   parameter int IMG_W   = 16,
   parameter int ACC_W   = 24,
   parameter int BN_W    = 16,
   parameter int N_CH    = 8,
   parameter int K_LEN   = 9,
   parameter int N_OUT   = 64,
   parameter int PRE_AW  = 10,
   parameter int NEXT_AW = 13,
   parameter int W_AW    = 9,
   parameter int BN_AW   = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pre_sram_full1,
   input  logic               pre_sram_full2,
   output logic               img_request1,
   output logic               img_request2,
   output logic               pre_en1,
   output logic               pre_en2,
   output logic               pre_rd,
   output logic [PRE_AW-1:0]  pre_addr,
   input  logic [IMG_W-1:0]   pre_data,
   output logic               weight_en,
   output logic [W_AW-1:0]    weight_addr,
   input  logic [N_CH-1:0]    weight_data,
   output logic               bn_en,
   output logic [BN_AW-1:0]   bn_addr,
   input  logic [BN_W:0]      bn_data,
   input  logic               next_sram_empty1,
   input  logic               next_sram_empty2,
   output logic               next_en1,
   output logic               next_en2,
   output logic               next_wr,
   output logic [NEXT_AW-1:0] next_addr,
   output logic [N_CH-1:0]    next_data,
   output logic               next_sram_full1,
   output logic               next_sram_full2,
   output logic               busy
);

   localparam int K_W = $clog2(K_LEN + 1);
   localparam int C_W = $clog2(N_CH + 1);
   localparam int O_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(K_LEN);
   localparam logic [C_W-1:0] C_LAST = C_W'(N_CH);
   localparam logic [O_W-1:0] O_LAST = O_W'(N_OUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MAC, S_BN, S_WRITE, S_DONE} state_t;

   state_t state, state_nx;
   logic [K_W-1:0] k_cnt;
   logic [C_W-1:0] c_cnt;
   logic [C_W-1:0] c_prev;
   logic [O_W-1:0] o_cnt;
   logic in_sel;   // 0 = bank1, 1 = bank2
   logic out_sel;  // 0 = bank1, 1 = bank2

   logic signed [ACC_W-1:0] acc [N_CH];
   logic signed [ACC_W-1:0] px_ext;
   logic signed [ACC_W-1:0] thr_ext;
   logic signed [ACC_W-1:0] acc_sel;
   logic                    bn_bit;
   logic [N_CH-1:0]         bits_q;
   logic [N_CH-1:0]         bits_nx;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // next-state and SRAM strobes; strobes are issued combinationally from the registered step counters
   always_comb begin
      state_nx        = state;
      pre_en1         = 1'b1;
      pre_en2         = 1'b1;
      pre_rd          = 1'b1;
      pre_addr        = '0;
      weight_en       = 1'b1;
      weight_addr     = '0;
      bn_en           = 1'b1;
      bn_addr         = '0;
      next_en1        = 1'b1;
      next_en2        = 1'b1;
      next_wr         = 1'b1;
      next_addr       = '0;
      img_request1    = 1'b0;
      img_request2    = 1'b0;
      next_sram_full1 = 1'b0;
      next_sram_full2 = 1'b0;
      busy            = 1'b0;
      case (state)
         S_IDLE: state_nx = S_WAIT;
         S_WAIT: begin
            // only the currently selected banks gate the start
            if ((in_sel ? pre_sram_full2 : pre_sram_full1) &&
                (out_sel ? next_sram_empty2 : next_sram_empty1))
               state_nx = S_MAC;
         end
         S_MAC: begin
            busy = 1'b1;
            if (k_cnt < K_LAST) begin
               pre_rd      = 1'b0;
               pre_en1     = in_sel;
               pre_en2     = !in_sel;
               pre_addr    = PRE_AW'(o_cnt) * PRE_AW'(K_LEN) + PRE_AW'(k_cnt);
               weight_en   = 1'b0;
               weight_addr = W_AW'(k_cnt);
            end else begin
               state_nx = S_BN;
            end
         end
         S_BN: begin
            busy = 1'b1;
            if (c_cnt < C_LAST) begin
               bn_en   = 1'b0;
               bn_addr = BN_AW'(c_cnt);
            end else begin
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            busy      = 1'b1;
            next_wr   = 1'b0;
            next_en1  = out_sel;
            next_en2  = !out_sel;
            next_addr = NEXT_AW'(o_cnt);
            state_nx  = (o_cnt == O_LAST) ? S_DONE : S_MAC;
         end
         S_DONE: begin
            busy            = 1'b1;
            img_request1    = !in_sel;
            img_request2    = in_sel;
            next_sram_full1 = !out_sel;
            next_sram_full2 = out_sel;
            state_nx        = S_WAIT;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // tap, channel and output-pixel counters plus bank selects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_cnt   <= '0;
         c_cnt   <= '0;
         o_cnt   <= '0;
         in_sel  <= 1'b0;
         out_sel <= 1'b0;
      end else begin
         k_cnt <= (state == S_MAC && k_cnt != K_LAST) ? k_cnt + 1'b1 : '0;
         c_cnt <= (state == S_BN && c_cnt != C_LAST) ? c_cnt + 1'b1 : '0;
         if (state == S_WAIT)
            o_cnt <= '0;
         else if (state == S_WRITE && o_cnt != O_LAST)
            o_cnt <= o_cnt + 1'b1;
         if (state == S_DONE) begin
            in_sel  <= !in_sel;
            out_sel <= !out_sel;
         end
      end
   end

   // sign extension, channel select for the threshold compare and result-bit insertion
   always_comb begin
      px_ext  = {{(ACC_W-IMG_W){pre_data[IMG_W-1]}}, pre_data};
      thr_ext = {{(ACC_W-BN_W){bn_data[BN_W-1]}}, bn_data[BN_W-1:0]};
      c_prev  = c_cnt - 1'b1;
      acc_sel = '0;
      for (int i = 0; i < N_CH; i++)
         if (c_prev == C_W'(i)) acc_sel = acc[i];
      bn_bit  = (acc_sel >= thr_ext) ^ bn_data[BN_W];
      bits_nx = bits_q;
      if (state == S_BN && c_cnt != '0)
         for (int i = 0; i < N_CH; i++)
            if (c_prev == C_W'(i)) bits_nx[i] = bn_bit;
   end

   // per-channel accumulators; the k=0 issue cycle has no data yet, so it clears instead
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      end else if (state == S_MAC) begin
         for (int i = 0; i < N_CH; i++) begin
            if (k_cnt == '0)        acc[i] <= '0;
            else if (weight_data[i]) acc[i] <= acc[i] + px_ext;
            else                     acc[i] <= acc[i] - px_ext;
         end
      end
   end

   // result bits collect during BN; the completed word is latched into next_data for WRITE and then held
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bits_q    <= '0;
         next_data <= '0;
      end else begin
         bits_q <= bits_nx;
         if (state == S_BN && c_cnt == C_LAST) next_data <= bits_nx;
      end
   end

endmodule

// File: tb/tb_bnn_layer_core.sv
// tb/tb_bnn_layer_core.sv - directed self-checking bench for bnn_layer_core
module tb_bnn_layer_core;

   localparam int N_OUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pre_sram_full1, pre_sram_full2;
   logic        img_request1, img_request2;
   logic        pre_en1, pre_en2, pre_rd;
   logic [9:0]  pre_addr;
   logic [15:0] pre_data;
   logic        weight_en;
   logic [8:0]  weight_addr;
   logic [7:0]  weight_data;
   logic        bn_en;
   logic [6:0]  bn_addr;
   logic [16:0] bn_data;
   logic        next_sram_empty1, next_sram_empty2;
   logic        next_en1, next_en2, next_wr;
   logic [12:0] next_addr;
   logic [7:0]  next_data;
   logic        next_sram_full1, next_sram_full2;
   logic        busy;

   bnn_layer_core #(.N_OUT(N_OUT)) dut (
      .clk(clk), .rst(rst),
      .pre_sram_full1(pre_sram_full1), .pre_sram_full2(pre_sram_full2),
      .img_request1(img_request1), .img_request2(img_request2),
      .pre_en1(pre_en1), .pre_en2(pre_en2), .pre_rd(pre_rd),
      .pre_addr(pre_addr), .pre_data(pre_data),
      .weight_en(weight_en), .weight_addr(weight_addr), .weight_data(weight_data),
      .bn_en(bn_en), .bn_addr(bn_addr), .bn_data(bn_data),
      .next_sram_empty1(next_sram_empty1), .next_sram_empty2(next_sram_empty2),
      .next_en1(next_en1), .next_en2(next_en2), .next_wr(next_wr),
      .next_addr(next_addr), .next_data(next_data),
      .next_sram_full1(next_sram_full1), .next_sram_full2(next_sram_full2),
      .busy(busy)
   );

   always #5 clk = ~clk;

   logic [15:0] mem1 [0:1023];
   logic [15:0] mem2 [0:1023];
   logic [7:0]  wmem [0:511];
   logic [16:0] bnmem [0:127];

   // synchronous-read SRAM models, 1-cycle latency
   always @(posedge clk) begin
      if (!pre_rd)    pre_data    <= !pre_en1 ? mem1[pre_addr] : mem2[pre_addr];
      if (!weight_en) weight_data <= wmem[weight_addr];
      if (!bn_en)     bn_data     <= bnmem[bn_addr];
   end

   int cyc = 0;
   int wr_bank[$], wr_addr[$], wr_data[$], wr_cyc[$], rd_start[$];
   int ir1 = 0, ir2 = 0, nf1 = 0, nf2 = 0;
   int pe1 = 0, pe2 = 0, ne1 = 0, ne2 = 0;
   int busy_cnt = 0, rd_cnt = 0;
   logic rd_prev = 1'b1;

   // bus monitor on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (!next_wr) begin
         wr_bank.push_back(next_en1 ? 2 : 1);
         wr_addr.push_back(int'(next_addr));
         wr_data.push_back(int'(next_data));
         wr_cyc.push_back(cyc);
      end
      if (!pre_rd && rd_prev) rd_start.push_back(cyc);
      rd_prev = pre_rd;
      if (img_request1)    ir1++;
      if (img_request2)    ir2++;
      if (next_sram_full1) nf1++;
      if (next_sram_full2) nf2++;
      if (!pre_en1)  pe1++;
      if (!pre_en2)  pe2++;
      if (!next_en1) ne1++;
      if (!next_en2) ne2++;
      if (busy)      busy_cnt++;
      if (!pre_rd)   rd_cnt++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (img_request1 || img_request2) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done"}, 32'(seen), 1);
      @(negedge clk);
   endtask

   task automatic check_tile(input string tag, input int wbase, input int bank, input int exp_data[N_OUT]);
      check({tag, "_nwr"}, wr_data.size() - wbase, N_OUT);
      for (int i = 0; i < N_OUT; i++) begin
         check($sformatf("%s_data%0d", tag, i), wr_data[wbase+i], exp_data[i]);
         check($sformatf("%s_addr%0d", tag, i), wr_addr[wbase+i], i);
         check($sformatf("%s_bank%0d", tag, i), wr_bank[wbase+i], bank);
      end
   endtask

   int wbase, rbase, a1, a2, f1, f2, p1, p2, n1, n2, b0, r0;
   int exp_t[N_OUT];

   task automatic snap();
      wbase = wr_data.size(); rbase = rd_start.size();
      a1 = ir1; a2 = ir2; f1 = nf1; f2 = nf2;
      p1 = pe1; p2 = pe2; n1 = ne1; n2 = ne2;
   endtask

   initial begin
      rst = 1'b0;
      pre_sram_full1 = 1'b0; pre_sram_full2 = 1'b0;
      next_sram_empty1 = 1'b0; next_sram_empty2 = 1'b0;
      for (int i = 0; i < 1024; i++) begin mem1[i] = '0; mem2[i] = '0; end
      for (int i = 0; i < 512; i++) wmem[i] = '0;
      for (int i = 0; i < 128; i++) bnmem[i] = '0;

      repeat (3) @(negedge clk);
      check("rst_strobes", 32'({pre_en1, pre_en2, pre_rd, weight_en, bn_en, next_en1, next_en2, next_wr}), 32'hFF);
      check("rst_pulses", 32'({busy, img_request1, img_request2, next_sram_full1, next_sram_full2}), 0);
      check("rst_addr", 32'(pre_addr) | 32'(weight_addr) | 32'(bn_addr) | 32'(next_addr), 0);
      check("rst_data", 32'(next_data), 0);
      rst = 1'b1;

      // tile 1 on bank1: AA, 55, FF, AA
      for (int k = 0; k < 9; k++) begin
         mem1[k]      = 16'd5;
         mem1[9 + k]  = (k < 8) ? 16'd5 : 16'(-50);
         mem1[18 + k] = 16'd0;
         mem1[27 + k] = 16'd1;
         wmem[k]      = 8'hAA;
      end
      exp_t = '{32'hAA, 32'h55, 32'hFF, 32'hAA};

      // stall: bank1 input full, bank1 output not empty, bank2 flags set but ignored
      pre_sram_full1 = 1'b1; pre_sram_full2 = 1'b1; next_sram_empty2 = 1'b1;
      b0 = busy_cnt; r0 = rd_cnt;
      repeat (51) @(negedge clk);
      check("stall_busy", busy_cnt - b0, 0);
      check("stall_rd", rd_cnt - r0, 0);
      check("stall_pre_rd", 32'(pre_rd), 1);

      pre_sram_full2 = 1'b0;
      snap();
      next_sram_empty1 = 1'b1;
      @(negedge clk);
      check("start_rd", 32'(pre_rd), 0);
      check("start_busy", 32'(busy), 1);
      check("start_bank", 32'({pre_en1, pre_en2}), 32'h1);
      wait_done("t1");
      check_tile("t1", wbase, 1, exp_t);
      check("t1_latency", wr_cyc[wbase] - rd_start[rbase], 19);
      check("t1_period", rd_start[rbase+1] - rd_start[rbase], 20);
      check("t1_pulses", (ir1-a1)*1000 + (ir2-a2)*100 + (nf1-f1)*10 + (nf2-f2), 1010);
      check("t1_other_bank", (pe2-p2) + (ne2-n2), 0);

      // tile 2 on bank2: flip on ch0, threshold 45 on ch1 -> AB
      pre_sram_full1 = 1'b0;
      for (int i = 0; i < N_OUT*9; i++) mem2[i] = 16'd5;
      bnmem[0] = {1'b1, 16'd0};
      bnmem[1] = {1'b0, 16'd45};
      exp_t = '{32'hAB, 32'hAB, 32'hAB, 32'hAB};
      snap();
      pre_sram_full2 = 1'b1;
      wait_done("t2");
      check_tile("t2", wbase, 2, exp_t);
      check("t2_pulses", (ir1-a1)*1000 + (ir2-a2)*100 + (nf1-f1)*10 + (nf2-f2), 101);
      check("t2_other_bank", (pe1-p1) + (ne1-n1), 0);

      // tile 3 back on bank1: extremes, max threshold, flip on ch3 -> F7 then 08
      pre_sram_full2 = 1'b0;
      for (int i = 0; i < N_OUT*9; i++) mem1[i] = (i < 9) ? 16'h8000 : 16'd0;
      for (int k = 0; k < 9; k++) wmem[k] = 8'h00;
      for (int c = 0; c < 8; c++) bnmem[c] = {(c == 3) ? 1'b1 : 1'b0, 16'h7FFF};
      exp_t = '{32'hF7, 32'h08, 32'h08, 32'h08};
      snap();
      pre_sram_full1 = 1'b1;
      wait_done("t3");
      check_tile("t3", wbase, 1, exp_t);
      check("t3_pulses", (ir1-a1)*1000 + (ir2-a2)*100 + (nf1-f1)*10 + (nf2-f2), 1010);

      // tile 4 on bank2, abandoned by reset mid-MAC
      pre_sram_full1 = 1'b0;
      pre_sram_full2 = 1'b1;
      begin
         logic started;
         started = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!pre_rd) begin started = 1'b1; break; end
         end
         check("t4_started", 32'(started), 1);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      pre_sram_full2 = 1'b0; next_sram_empty1 = 1'b0; next_sram_empty2 = 1'b0;
      #1;
      check("mid_rst_strobes", 32'({pre_en1, pre_en2, pre_rd, weight_en, bn_en, next_en1, next_en2, next_wr}), 32'hFF);
      check("mid_rst_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      snap();
      b0 = busy_cnt;
      repeat (21) @(negedge clk);
      check("post_rst_pulses", (ir1-a1) + (ir2-a2) + (nf1-f1) + (nf2-f2), 0);
      check("post_rst_writes", wr_data.size() - wbase, 0);
      check("post_rst_busy", busy_cnt - b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
